// File: rtl/store_rmw_ctrl_if.sv
// ============================================================================
// Module   : store_rmw_ctrl_if
// Purpose  : Bundles the LSU request/response and data-RAM signals of store_rmw_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface store_rmw_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // master: the LSU plus the RAM; slave: the sequencer itself
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/store_rmw_ctrl.sv
// ============================================================================
// Module   : store_rmw_ctrl
// Purpose  : Load/store sequencer; sub-word stores are read-modify-write on a word RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_rmw_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  store_rmw_ctrl_if.slave     bus
);

  localparam logic [1:0] C_SZ_BYTE = 2'b00;
  localparam logic [1:0] C_SZ_HALF = 2'b01;
  localparam logic [1:0] C_SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata_q;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_misaligned;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merge;

  assign w_accept     = bus.req_valid && bus.req_ready;
  assign w_misaligned = (bus.req_size == 2'b11) ||
                        (bus.req_size == C_SZ_HALF && bus.req_addr[0]) ||
                        (bus.req_size == C_SZ_WORD && bus.req_addr[1:0] != 2'b00);

  // Lane extraction works on the live RAM output so the result is ready at WAIT->RESP
  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0:    w_byte = bus.mem_rdata[7:0];
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_size)
      C_SZ_BYTE: w_load = {{(DATA_WIDTH-8){~r_unsigned & w_byte[7]}}, w_byte};
      C_SZ_HALF: w_load = {{(DATA_WIDTH-16){~r_unsigned & w_half[15]}}, w_half};
      default:   w_load = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = r_rdata_q;
    case (r_size)
      C_SZ_BYTE: begin
        case (r_addr[1:0])
          2'd0:    w_merge[7:0]   = r_wdata[7:0];
          2'd1:    w_merge[15:8]  = r_wdata[7:0];
          2'd2:    w_merge[23:16] = r_wdata[7:0];
          default: w_merge[31:24] = r_wdata[7:0];
        endcase
      end
      C_SZ_HALF: begin
        if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata_q    <= '0;
      r_resp_rdata <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we       <= bus.req_we;
        r_size     <= bus.req_size;
        r_unsigned <= bus.req_unsigned;
        r_addr     <= bus.req_addr;
        r_wdata    <= bus.req_wdata;
        r_err      <= w_misaligned;
      end
      if (r_state == S_WAIT) begin
        r_rdata_q <= bus.mem_rdata;
        if (!r_we) r_resp_rdata <= w_load;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        // rst_n gates ready so nothing is accepted while reset is held
        bus.req_ready = rst_n;
        if (w_accept) begin
          if (w_misaligned)                          w_next = S_RESP;
          else if (bus.req_we && bus.req_size == C_SZ_WORD) w_next = S_WR;
          else                                       w_next = S_RD;
        end
      end
      S_RD: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = r_addr[ADDR_WIDTH-1:2];
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        w_next = r_we ? S_WR : S_RESP;
      end
      S_WR: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_addr[ADDR_WIDTH-1:2];
        bus.mem_wdata = w_merge;
        w_next        = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = r_err;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.resp_rdata = r_resp_rdata;

endmodule

`default_nettype wire
